// File: rtl/vga_grid_renderer.sv
// VGA raster scanner: walks the 800x525 timing grid, addresses the snake-world
// cell memory, and turns the returned cell code into pixel colour and syncs.
module vga_grid_renderer #(
  parameter int H_VIS     = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VIS     = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int X_OFF     = 80,
  parameter int CELL_LOG2 = 5,
  parameter int GRID_N    = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  input  logic [1:0] cell_data,
  output logic [3:0] x_loc_vga,
  output logic [3:0] y_loc_vga,
  output logic       hsync,
  output logic       vsync,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       frame_start
);

  localparam int H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int GRID_PIX = GRID_N << CELL_LOG2;

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_LO      = 10'(X_OFF);
  localparam logic [9:0] X_HI      = 10'(X_OFF + GRID_PIX);
  localparam logic [9:0] Y_HI      = 10'(GRID_PIX);
  localparam logic [9:0] H_ACT     = 10'(H_VIS);
  localparam logic [9:0] V_ACT     = 10'(V_VIS);
  localparam logic [9:0] HS_LO     = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_HI     = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_LO     = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_HI     = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [9:0] CELL_MASK = 10'((1 << CELL_LOG2) - 1);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic [9:0] h_rel;
  logic       in_grid;
  logic       grid_line;

  logic in_grid_p1;
  logic grid_line_p1;
  logic active_p1;
  logic hs_p1;
  logic vs_p1;

  function automatic logic [11:0] pick_colour(input logic       active,
                                              input logic       grid,
                                              input logic       line,
                                              input logic [1:0] code);
    if (!active) return 12'h000;
    if (!grid)   return 12'h00F;
    if (line)    return 12'h444;
    case (code)
      2'b00:   return 12'h111;
      2'b01:   return 12'hF00;
      2'b10:   return 12'h0F0;
      default: return 12'hFF0;
    endcase
  endfunction

  // h_rel is only meaningful inside the grid, where it cannot underflow
  assign h_rel     = h_cnt - X_LO;
  assign in_grid   = (h_cnt >= X_LO) && (h_cnt < X_HI) && (v_cnt < Y_HI);
  assign grid_line = in_grid && (((h_rel & CELL_MASK) == '0) || ((v_cnt & CELL_MASK) == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt        <= '0;
      v_cnt        <= '0;
      x_loc_vga    <= '0;
      y_loc_vga    <= '0;
      in_grid_p1   <= 1'b0;
      grid_line_p1 <= 1'b0;
      active_p1    <= 1'b0;
      hs_p1        <= 1'b1;
      vs_p1        <= 1'b1;
      hsync        <= 1'b1;
      vsync        <= 1'b1;
      red          <= '0;
      green        <= '0;
      blue         <= '0;
      frame_start  <= 1'b0;
    end else begin
      frame_start <= pix_en && (h_cnt == H_LAST) && (v_cnt == V_LAST);
      if (pix_en) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        end else begin
          h_cnt <= h_cnt + 10'd1;
        end

        // Stage 1: memory address and raster flags
        x_loc_vga    <= in_grid ? 4'(h_rel >> CELL_LOG2) : 4'd0;
        y_loc_vga    <= in_grid ? 4'(v_cnt >> CELL_LOG2) : 4'd0;
        in_grid_p1   <= in_grid;
        grid_line_p1 <= grid_line;
        active_p1    <= (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs_p1        <= !((h_cnt >= HS_LO) && (h_cnt < HS_HI));
        vs_p1        <= !((v_cnt >= VS_LO) && (v_cnt < VS_HI));

        // Stage 2: colour from the cell code, syncs kept aligned with it
        {red, green, blue} <= pick_colour(active_p1, in_grid_p1, grid_line_p1, cell_data);
        hsync              <= hs_p1;
        vsync              <= vs_p1;
      end
    end
  end

endmodule
